// File: rtl/sar_search.sv
// sar_search: successive-approximation controller for an external comparator.
// Recovers a hidden unsigned operand A, MSB first, in at most WIDTH probes.
module sar_search #(
    parameter int WIDTH = 3,
    parameter int LAT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PROBE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] trial_n;
    logic [WIDTH-1:0] result_n;
    logic             err_n;
    logic [IW-1:0]    idx, idx_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             one_hot;

    assign one_hot = ( cmp_gt & ~cmp_lt & ~cmp_eq) |
                     (~cmp_gt &  cmp_lt & ~cmp_eq) |
                     (~cmp_gt & ~cmp_lt &  cmp_eq);

    assign busy = (state == PROBE) || (state == WAIT);
    assign done = (state == FINISH);

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            trial  <= '0;
            idx    <= '0;
            cnt    <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            trial  <= trial_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
            result <= result_n;
            err    <= err_n;
        end
    end

    // Next-state logic: trial only moves at start and at PROBE edges.
    always_comb begin
        state_n  = state;
        trial_n  = trial;
        idx_n    = idx;
        cnt_n    = cnt;
        result_n = result;
        err_n    = err;
        unique case (state)
            IDLE: begin
                if (start) begin
                    trial_n = MSB;
                    idx_n   = IW'(WIDTH - 1);
                    err_n   = 1'b0;
                    if (LAT == 0) begin
                        state_n = PROBE;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CW'(LAT);
                    end
                end
            end
            WAIT: begin
                cnt_n = cnt - CW'(1);
                if (cnt <= CW'(1)) begin
                    cnt_n   = '0;
                    state_n = PROBE;
                end
            end
            PROBE: begin
                if (!one_hot) begin
                    err_n    = 1'b1;
                    result_n = trial;
                    trial_n  = '0;
                    state_n  = FINISH;
                end else if (cmp_eq) begin
                    result_n = trial;
                    trial_n  = '0;
                    state_n  = FINISH;
                end else if (idx == '0) begin
                    // Last bit: LT clears it, GT means A is beyond all-ones.
                    if (cmp_lt) begin
                        result_n = {trial[WIDTH-1:1], 1'b0};
                    end else begin
                        err_n    = 1'b1;
                        result_n = trial;
                    end
                    trial_n = '0;
                    state_n = FINISH;
                end else begin
                    if (cmp_lt) begin
                        trial_n[idx] = 1'b0;
                    end
                    trial_n[idx - IW'(1)] = 1'b1;
                    idx_n = idx - IW'(1);
                    if (LAT > 0) begin
                        state_n = WAIT;
                        cnt_n   = CW'(LAT);
                    end
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
